piece_plotter: RTL and testbench



---
 rtl/piece_plotter_pkg.sv | 26 ++
 rtl/piece_plotter_if.sv | 29 ++
 rtl/piece_cell_addr.sv | 24 ++
 rtl/piece_plotter.sv | 168 ++++++++++++++++
 tb/tb_piece_plotter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/piece_plotter_pkg.sv
// Shared widths, board defaults and FSM encoding for the tetromino plotter.
package piece_plotter_pkg;

  localparam int COLOUR_W       = 6;
  localparam int OFF_W          = 2;
  localparam int N_CELLS        = 4;
  localparam int CNT_W          = 3;
  localparam int BOARD_COLS_DEF = 10;
  localparam int BOARD_ROWS_DEF = 20;
  localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF = 6'b00_00_00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Extracts the 2-bit offset of one cell from a packed offset byte.
  function automatic logic [OFF_W-1:0] cell_off(
    input logic [N_CELLS*OFF_W-1:0] packed_off,
    input logic [1:0]               idx
  );
    return packed_off[idx*OFF_W +: OFF_W];
  endfunction

endpackage

// File: rtl/piece_plotter_if.sv
// Command and VGA-adapter signals between controller, plotter and frame buffer.
interface piece_plotter_if
  import piece_plotter_pkg::*;
;
  logic                start;
  logic                erase;
  logic [3:0]          board_x;
  logic [4:0]          board_y;
  logic [7:0]          cell_x;
  logic [7:0]          cell_y;
  logic [COLOUR_W-1:0] cell_colour;
  logic                busy;
  logic                done;
  logic                plot;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;

  modport master (
    output start, erase, board_x, board_y, cell_x, cell_y, cell_colour,
    input  busy, done, plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  start, erase, board_x, board_y, cell_x, cell_y, cell_colour,
    output busy, done, plot, vga_x, vga_y, vga_colour
  );

endinterface

// File: rtl/piece_cell_addr.sv
// Board coordinate of one tetromino cell plus its on-board flag (combinational).
module piece_cell_addr
  import piece_plotter_pkg::*;
#(
  parameter int BOARD_COLS = BOARD_COLS_DEF,
  parameter int BOARD_ROWS = BOARD_ROWS_DEF
) (
  input  logic [1:0] cell_i,
  input  logic [7:0] off_x_i,
  input  logic [7:0] off_y_i,
  input  logic [3:0] board_x_i,
  input  logic [4:0] board_y_i,
  output logic [5:0] cx_o,
  output logic [5:0] cy_o,
  output logic       in_bounds_o
);

  // 6 bits hold the largest sum (31 + 3) without wrapping.
  assign cx_o = 6'(board_x_i) + 6'(cell_off(off_x_i, cell_i));
  assign cy_o = 6'(board_y_i) + 6'(cell_off(off_y_i, cell_i));

  assign in_bounds_o = (cx_o < 6'(BOARD_COLS)) && (cy_o < 6'(BOARD_ROWS));

endmodule

// File: rtl/piece_plotter.sv
// Draws or erases one tetromino as CELL_PX-square cells, one registered pixel per cycle.
module piece_plotter
  import piece_plotter_pkg::*;
#(
  parameter int                  CELL_PX    = 4,
  parameter int                  BOARD_X0   = 0,
  parameter int                  BOARD_Y0   = 0,
  parameter int                  BOARD_COLS = BOARD_COLS_DEF,
  parameter int                  BOARD_ROWS = BOARD_ROWS_DEF,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = BG_COLOUR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  piece_plotter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_PX = CNT_W'(CELL_PX - 1);

  state_e              state_q, state_d;
  logic                erase_q, erase_d;
  logic [3:0]          board_x_q, board_x_d;
  logic [4:0]          board_y_q, board_y_d;
  logic [7:0]          cell_x_q, cell_x_d;
  logic [7:0]          cell_y_q, cell_y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [1:0]          cell_q, cell_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                plot_q, plot_d;
  logic [7:0]          vga_x_q, vga_x_d;
  logic [6:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;

  logic       emit;
  logic [5:0] cx, cy;
  logic       in_bounds;

  // Addressed with next-cycle operands so the pixel leaves on a register.
  piece_cell_addr #(
    .BOARD_COLS (BOARD_COLS),
    .BOARD_ROWS (BOARD_ROWS)
  ) u_addr (
    .cell_i      (cell_d),
    .off_x_i     (cell_x_d),
    .off_y_i     (cell_y_d),
    .board_x_i   (board_x_d),
    .board_y_i   (board_y_d),
    .cx_o        (cx),
    .cy_o        (cy),
    .in_bounds_o (in_bounds)
  );

  always_comb begin
    state_d      = state_q;
    erase_d      = erase_q;
    board_x_d    = board_x_q;
    board_y_d    = board_y_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    colour_d     = colour_q;
    cell_d       = cell_q;
    row_d        = row_q;
    col_d        = col_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    plot_d       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    emit         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          erase_d   = bus.erase;
          board_x_d = bus.board_x;
          board_y_d = bus.board_y;
          cell_x_d  = bus.cell_x;
          cell_y_d  = bus.cell_y;
          colour_d  = bus.cell_colour;
          cell_d    = '0;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_DRAW;
          emit      = 1'b1;
        end
      end
      S_DRAW: begin
        if (cell_q == 2'(N_CELLS - 1) && row_q == LAST_PX && col_q == LAST_PX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
          if (col_q == LAST_PX) begin
            col_d = '0;
            if (row_q == LAST_PX) begin
              row_d  = '0;
              cell_d = cell_q + 2'd1;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clipped cells still spend their cycles, just without the write strobe.
    if (emit) begin
      busy_d       = 1'b1;
      plot_d       = in_bounds;
      vga_x_d      = 8'(BOARD_X0) + 8'(cx) * 8'(CELL_PX) + 8'(col_d);
      vga_y_d      = 7'(BOARD_Y0) + 7'(cy) * 7'(CELL_PX) + 7'(row_d);
      vga_colour_d = erase_d ? BG_COLOUR : colour_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      erase_q      <= 1'b0;
      board_x_q    <= '0;
      board_y_q    <= '0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      colour_q     <= '0;
      cell_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      erase_q      <= erase_d;
      board_x_q    <= board_x_d;
      board_y_q    <= board_y_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      colour_q     <= colour_d;
      cell_q       <= cell_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.plot       = plot_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_piece_plotter.sv
// Random and directed draws of piece_plotter checked against a pixel-list model.
module tb_piece_plotter;

  localparam int CP   = 4;
  localparam int BX0  = 0;
  localparam int BY0  = 0;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int NPIX = 4 * CP * CP;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   np;

  piece_plotter_if bus ();

  piece_plotter #(
    .CELL_PX    (CP),
    .BOARD_X0   (BX0),
    .BOARD_Y0   (BY0),
    .BOARD_COLS (COLS),
    .BOARD_ROWS (ROWS),
    .BG_COLOUR  (6'b00_00_00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    bus.erase       = 1'($urandom);
    bus.board_x     = 4'($urandom);
    bus.board_y     = 5'($urandom);
    bus.cell_x      = 8'($urandom);
    bus.cell_y      = 8'($urandom);
    bus.cell_colour = 6'($urandom);
  endtask

  // Expected pixel stream: cells in order, rows, then columns fastest.
  task automatic run_op(input logic er, input logic [3:0] bx, input logic [4:0] by,
                        input logic [7:0] ox, input logic [7:0] oy, input logic [5:0] co,
                        input int pulse_at, input bit hold, output int nplots);
    int ep[NPIX];
    int ex[NPIX];
    int ey[NPIX];
    int ecol, idx, gx, gy, dones;
    ecol = er ? 0 : int'(co);
    idx  = 0;
    for (int c = 0; c < 4; c++) begin
      gx = int'(bx) + ((int'(ox) >> (2 * c)) & 3);
      gy = int'(by) + ((int'(oy) >> (2 * c)) & 3);
      for (int r = 0; r < CP; r++)
        for (int k = 0; k < CP; k++) begin
          ep[idx] = (gx < COLS && gy < ROWS) ? 1 : 0;
          ex[idx] = (BX0 + gx * CP + k) % 256;
          ey[idx] = (BY0 + gy * CP + r) % 128;
          idx++;
        end
    end

    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_done", int'(bus.done), 0);
    bus.start       = 1'b1;
    bus.erase       = er;
    bus.board_x     = bx;
    bus.board_y     = by;
    bus.cell_x      = ox;
    bus.cell_y      = oy;
    bus.cell_colour = co;

    nplots = 0;
    dones  = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      chk("busy", int'(bus.busy), 1);
      chk("plot", int'(bus.plot), ep[i]);
      chk("vga_x", int'(bus.vga_x), ex[i]);
      chk("vga_y", int'(bus.vga_y), ey[i]);
      chk("colour", int'(bus.vga_colour), ecol);
      nplots += int'(bus.plot);
      dones  += int'(bus.done);
      if (!hold) begin
        scramble_inputs();
        bus.start = (i == pulse_at);
      end
    end
    chk("done_in_draw", dones, 0);

    @(negedge clk);
    chk("done_pulse", int'(bus.done), 1);
    chk("done_busy", int'(bus.busy), 0);
    chk("done_plot", int'(bus.plot), 0);
    if (!hold) bus.start = 1'b0;

    if (pulse_at >= 0) begin
      repeat (2) begin
        @(negedge clk);
        chk("no_queue_busy", int'(bus.busy), 0);
        chk("no_queue_done", int'(bus.done), 0);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.erase       = 1'b0;
    bus.board_x     = '0;
    bus.board_y     = '0;
    bus.cell_x      = '0;
    bus.cell_y      = '0;
    bus.cell_colour = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_x", int'(bus.vga_x), 0);
    chk("rst_y", int'(bus.vga_y), 0);
    chk("rst_colour", int'(bus.vga_colour), 0);
    reset = 1'b0;

    run_op(1'b0, 4'd3, 5'd0, 8'b00_01_10_11, 8'h00, 6'b00_11_11, -1, 1'b0, np);
    chk("i_plots", np, 64);
    run_op(1'b1, 4'd3, 5'd0, 8'b00_01_10_11, 8'h00, 6'b00_11_11, -1, 1'b0, np);
    chk("erase_plots", np, 64);
    run_op(1'b0, 4'd9, 5'd19, 8'b01_00_01_00, 8'b01_01_00_00, 6'b11_00_00, -1, 1'b0, np);
    chk("o_clip_plots", np, 16);
    run_op(1'b0, 4'd3, 5'd0, 8'b00_01_10_11, 8'h00, 6'b00_11_11, 8, 1'b0, np);
    chk("pulse_plots", np, 64);

    // Reset sampled at the twentieth edge after start.
    @(negedge clk);
    bus.start       = 1'b1;
    bus.erase       = 1'b0;
    bus.board_x     = 4'd3;
    bus.board_y     = 5'd0;
    bus.cell_x      = 8'b00_01_10_11;
    bus.cell_y      = 8'h00;
    bus.cell_colour = 6'b00_11_11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 19) begin
        chk("pre_rst_busy", int'(bus.busy), 1);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_plot", int'(bus.plot), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    reset = 1'b0;
    run_op(1'b0, 4'd3, 5'd0, 8'b00_01_10_11, 8'h00, 6'b00_11_11, -1, 1'b0, np);
    chk("post_rst_plots", np, 64);

    // Start held high: one idle cycle separates the done pulse and the next draw.
    run_op(1'b0, 4'd0, 5'd5, 8'b10_01_00_00, 8'b00_00_01_00, 6'b10_10_01, -1, 1'b1, np);
    run_op(1'b0, 4'd0, 5'd5, 8'b10_01_00_00, 8'b00_00_01_00, 6'b10_10_01, -1, 1'b1, np);
    bus.start = 1'b0;
    chk("hold_plots", np, 64);

    for (int t = 0; t < 8; t++) begin
      run_op(1'($urandom), 4'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
             6'($urandom), -1, 1'b0, np);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
